eq_share_arbiter: RTL

- Shares one registered equality comparator between NREQ requesters.
- Each requester offers an operand pair (a, b) through a valid/ready handshake.
- A round-robin arbiter grants one requester, the comparator evaluates a == b, and the result is returned tagged with the requester id.
- Sits between compiled datapath clients and the eq primitive; it is the scheduler for that shared resource.

---
 rtl/eq_share_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/eq_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : eq_share_arbiter
//  Purpose  : Time-shares a single registered equality comparator between
//             NREQ requesters. A round-robin arbiter picks one requester,
//             latches its operand pair, compares a == b in a dedicated cycle
//             and returns the result tagged with the requester id.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock      in   1           rising-edge clock
//    reset      in   1           asynchronous, active-low reset
//    req_valid  in   NREQ        requester i has an operand pair
//    req_ready  out  NREQ        one-hot grant (IDLE only, combinational)
//    req_a      in   NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//    req_b      in   NREQ*WIDTH  operand b, same packing as req_a
//    rsp_valid  out  1           result available
//    rsp_ready  in   1           consumer accepts result
//    rsp_id     out  IDW         requester owning the result
//    rsp_eq     out  1           1 when a == b
//    busy       out  1           FSM not in IDLE
//    match_cnt  out  CNTW        saturating count of retired matches
// ============================================================================
module eq_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_eq,
    output logic                    busy,
    output logic [CNTW-1:0]         match_cnt
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (IDW != $clog2(NREQ)) begin : g_bad_idw
        $error("eq_share_arbiter: IDW must equal clog2(NREQ)");
    end
    if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
        $error("eq_share_arbiter: NREQ must be in 2..8");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("eq_share_arbiter: WIDTH must be >= 1");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_eq;
    logic             r_rsp_valid;
    logic             r_busy;
    logic [CNTW-1:0]  r_cnt;

    logic             w_found;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_cand;
    int               w_idx;

    // ------------------------------------------------------------------------
    // Round-robin pick: scan offsets from the highest down so the candidate
    // closest to r_ptr (offset 0) is the last one written and therefore wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        w_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            w_cand = IDW'(w_idx);
            if (req_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    // Grant is offered only in IDLE; gating with reset keeps req_ready low
    // for the whole time reset is held, independent of the clock.
    always_comb begin
        req_ready = '0;
        if (reset && (r_state == S_IDLE) && w_found) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_eq        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a     <= req_a[w_grant*WIDTH +: WIDTH];
                        r_b     <= req_b[w_grant*WIDTH +: WIDTH];
                        r_id    <= w_grant;
                        r_busy  <= 1'b1;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_eq        <= (r_a == r_b);
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // The pointer moves only on retirement, so a stalled
                    // consumer never lets the arbiter skip past anyone.
                    if (rsp_ready) begin
                        r_ptr       <= (r_id == c_last_id) ? '0 : r_id + 1'b1;
                        if (r_eq && (r_cnt != '1)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_eq    = r_eq;
    assign busy      = r_busy;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire
